param_sync_fifo: RTL



---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_mem.sv | 27 ++
 rtl/param_sync_fifo.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO family.
// Read-mode selectors and a constant-evaluable power-of-two test for parameter checks.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DWIDTH storage for param_sync_fifo: one synchronous write port and
// one asynchronous read port, so the FWFT mode can present the head word directly.
module fifo_mem #(
    parameter  int DWIDTH = 32,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    // Contents are deliberately not reset; occupancy tracking makes stale words invisible.
    logic [DWIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, occupancy count, programmable
// almost-full/empty thresholds, standard or FWFT read, sticky error flags and flush.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DWIDTH   = 32,
    parameter int DEPTH    = 16,
    parameter int FWFT     = FIFO_STD,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   clr_err,
    input  logic                   w_en,
    input  logic [DWIDTH-1:0]      din,
    input  logic                   r_en,
    output logic [DWIDTH-1:0]      dout,
    output logic                   dout_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] AF_TH = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_TH = CW'(AE_LEVEL);
    localparam logic [CW-1:0] ONE   = CW'(1);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH=%0d must be a power of two >= 2", DEPTH);
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("param_sync_fifo: AF_LEVEL=%0d outside 1..DEPTH", AF_LEVEL);
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("param_sync_fifo: AE_LEVEL=%0d outside 0..DEPTH-1", AE_LEVEL);
    end
    if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
        $error("param_sync_fifo: FWFT=%0d must be 0 or 1", FWFT);
    end

    logic [CW-1:0]     wptr_q, wptr_d;
    logic [CW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              rd_ok, wr_ok;
    logic              rd_acc, wr_acc;
    logic [AW-1:0]     waddr, raddr;
    logic [DWIDTH-1:0] rdata;

    assign waddr = wptr_q[AW-1:0];
    assign raddr = rptr_q[AW-1:0];

    // Same address with opposite wrap bits means the writer is a full lap ahead.
    assign empty = (wptr_q == rptr_q);
    assign full  = (waddr == raddr) && (wptr_q[CW-1] != rptr_q[CW-1]);

    assign almost_full  = (count_q >= AF_TH);
    assign almost_empty = (count_q <= AE_TH);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a write.
    // Flush suppresses both the transfer and any error it would have raised.
    assign rd_ok  = r_en & ~empty;
    assign wr_ok  = w_en & (~full | rd_ok);
    assign rd_acc = rd_ok & ~flush;
    assign wr_acc = wr_ok & ~flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + ONE;
            if (rd_acc) rptr_d = rptr_q + ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
        end
        // A fresh error in the same cycle as clr_err keeps the flag set.
        overflow_d  = (overflow_q  & ~clr_err) | (w_en & ~wr_ok & ~flush);
        underflow_d = (underflow_q & ~clr_err) | (r_en & empty & ~flush);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (waddr),
        .wdata (din),
        .raddr (raddr),
        .rdata (rdata)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Head word is always on dout; r_en just advances past it.
        assign dout       = rdata;
        assign dout_valid = ~empty;
    end else begin : g_std
        logic [DWIDTH-1:0] dout_q, dout_d;
        logic              dout_valid_q, dout_valid_d;

        always_comb begin
            dout_d       = rd_acc ? rdata : dout_q;
            dout_valid_d = rd_acc;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                dout_q       <= dout_d;
                dout_valid_q <= dout_valid_d;
            end
        end

        assign dout       = dout_q;
        assign dout_valid = dout_valid_q;
    end

endmodule
